alt_reset_seq: RTL

- Parametrised multi-channel successor to the single-channel reset-delay filter.
- Takes NUM_CH asynchronous ready conditions (PLL locks, SERDES ready, etc.), synchronises each one and releases them strictly in order. Each channel's ready_out asserts a programmable DELAY cycles after its own input is stable and the previous channel is ready.
- Provides sticky per-channel loss flags for status CSRs.
- Sits between clock/PHY status sources and the per-domain reset logic of the HSSI packet client.

---
 rtl/alt_reset_seq_pkg.sv | 32 +++
 rtl/alt_reset_seq_ch.sv | 88 ++++++++
 rtl/alt_reset_seq.sv | 48 ++++
 3 files changed

// File: rtl/alt_reset_seq_pkg.sv
// alt_reset_seq_pkg: shared types and constants for the reset sequencer.
// Holds the per-channel state encoding and the effective delay/sync-depth
// helpers. Define ALT_RESET_SEQ_FAST_SIM_EN to shorten delays for simulation.
package alt_reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } ch_state_e;

    localparam int FAST_SIM_DELAY = 16;

    // Delay actually used by each channel's counter.
    function automatic int eff_delay(input int d);
`ifdef ALT_RESET_SEQ_FAST_SIM_EN
        return (d < FAST_SIM_DELAY) ? d : FAST_SIM_DELAY;
`else
        return d;
`endif
    endfunction

    // Synchroniser depth actually built on each ready_in bit.
    function automatic int eff_sync(input int s);
`ifdef ALT_RESET_SEQ_FAST_SIM_EN
        return (s > 0) ? 2 : 2;
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/alt_reset_seq_ch.sv
// alt_reset_seq_ch: one sequencer channel (synchroniser, FSM, delay counter,
// sticky lost flag). Ports: clk, rst (sync, active-high), ready_in (async),
// up_ok (upstream channel ready), lost_clr, ready_out, lost, state (debug).
// Honours ALT_RESET_SEQ_FAST_SIM_EN through the package helpers.
module alt_reset_seq_ch
    import alt_reset_seq_pkg::*;
#(
    parameter int DELAY       = 32768,
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_in,
    input  logic       up_ok,
    input  logic       lost_clr,
    output logic       ready_out,
    output logic       lost,
    output logic [1:0] state
);

    localparam int EFF_DELAY = eff_delay(DELAY);
    localparam int SS        = eff_sync(SYNC_STAGES);
    localparam int CW        = $clog2(EFF_DELAY);

    logic [SS-1:0] sync;
    logic          ch_ok;
    ch_state_e     st;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SS-2:0], ready_in};
        end
    end

    assign ch_ok = sync[SS-1] & up_ok;
    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            ready_out <= 1'b0;
            lost      <= 1'b0;
        end else begin
            // A set from leaving READY below overrides this clear.
            if (lost_clr) begin
                lost <= 1'b0;
            end
            case (st)
                IDLE: begin
                    cnt <= '0;
                    if (ch_ok) begin
                        st  <= WAIT;
                        cnt <= CW'(1);
                    end
                end
                WAIT: begin
                    if (!ch_ok) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (cnt == CW'(EFF_DELAY - 1)) begin
                        st        <= READY;
                        ready_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                READY: begin
                    if (!ch_ok) begin
                        st        <= IDLE;
                        cnt       <= '0;
                        ready_out <= 1'b0;
                        lost      <= 1'b1;
                    end
                end
                default: begin
                    st        <= IDLE;
                    cnt       <= '0;
                    ready_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alt_reset_seq.sv
// alt_reset_seq: releases NUM_CH asynchronous ready conditions in order.
// Ports: clk, rst (sync, active-high), ready_in, lost_clr, ready_out,
// all_ready, lost, ch_state. Macro ALT_RESET_SEQ_FAST_SIM_EN shortens delays.
module alt_reset_seq
    import alt_reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DELAY       = 32768,
    parameter int SYNC_STAGES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ready_in,
    input  logic [NUM_CH-1:0]   lost_clr,
    output logic [NUM_CH-1:0]   ready_out,
    output logic                all_ready,
    output logic [NUM_CH-1:0]   lost,
    output logic [2*NUM_CH-1:0] ch_state
);

    logic [NUM_CH-1:0] up_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel i may only start once channel i-1 is released.
        if (i == 0) begin : g_first
            assign up_ok[i] = 1'b1;
        end else begin : g_next
            assign up_ok[i] = ready_out[i-1];
        end

        alt_reset_seq_ch #(
            .DELAY       (DELAY),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .ready_in  (ready_in[i]),
            .up_ok     (up_ok[i]),
            .lost_clr  (lost_clr[i]),
            .ready_out (ready_out[i]),
            .lost      (lost[i]),
            .state     (ch_state[2*i +: 2])
        );
    end

    assign all_ready = &ready_out;

endmodule
